// File: rtl/param_frame_loader_pkg.sv
// Shared types for the double-buffered render parameter loader.
package param_frame_loader_pkg;

    typedef enum logic { LD_FILL = 1'b0, LD_FULL = 1'b1 } ld_state_e;
    typedef enum logic { ACT_EMPTY = 1'b0, ACT_RUN = 1'b1 } act_state_e;

    // Beat index must also reach NUM_PARAMS, the slot of the repeat-count beat.
    function automatic int idx_width(input int num_params);
        return $clog2(num_params + 1);
    endfunction

endpackage

// File: rtl/param_frame_loader_bank.sv
// NUM_PARAMS x DATA_W register bank: single-entry write port plus whole-bank load.
module param_bank
    import param_frame_loader_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_PARAMS = 4,
    parameter int IDX_W      = idx_width(NUM_PARAMS)
) (
    input  logic                         ACLK,
    input  logic                         RESET_N,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         load_en,
    input  logic [NUM_PARAMS*DATA_W-1:0] load_data,
    output logic [NUM_PARAMS*DATA_W-1:0] rd_data
);

    logic [NUM_PARAMS-1:0][DATA_W-1:0] regs;

    // A whole-bank load wins over the single-entry port so a copy is never mixed.
    always_ff @(posedge ACLK) begin
        if (!RESET_N) begin
            regs <= '0;
        end else if (load_en) begin
            regs <= load_data;
        end else begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                if (wr_en && wr_idx == IDX_W'(i)) regs[i] <= wr_data;
            end
        end
    end

    assign rd_data = regs;

endmodule

// File: rtl/param_frame_loader.sv
// Double-buffered per-frame parameter loader: a byte stream fills a shadow bank,
// which is published to the active bank and held for a counted number of uses.
module param_frame_loader
    import param_frame_loader_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_PARAMS = 4
) (
    input  logic                         ACLK,
    input  logic                         RESET_N,
    input  logic [DATA_W-1:0]            RByt,
    input  logic                         RValid,
    output logic                         RReady,
    input  logic                         NEXT,
    output logic [NUM_PARAMS*DATA_W-1:0] PARAMS,
    output logic                         PARAM_VALID,
    output logic [DATA_W-1:0]            REMAINING,
    output logic                         FINISH,
    output logic                         FINISH_READ,
    output logic                         NEXT_ERR
);

    localparam int IDX_W = idx_width(NUM_PARAMS);
    localparam logic [IDX_W-1:0] CNT_IDX = IDX_W'(NUM_PARAMS);

    ld_state_e                   ld_state, ld_next;
    act_state_e                  act_state, act_next;
    logic                        rdy_en;
    logic [IDX_W-1:0]            wr_idx;
    logic [DATA_W-1:0]           count_q;
    logic [NUM_PARAMS*DATA_W-1:0] shadow_data;

    logic transfer, param_beat, count_beat, last_use, swap;

    assign transfer   = RValid && RReady;
    assign param_beat = transfer && (wr_idx != CNT_IDX);
    assign count_beat = transfer && (wr_idx == CNT_IDX);
    assign last_use   = (act_state == ACT_RUN) && NEXT && (REMAINING == DATA_W'(1));
    assign swap       = (ld_state == LD_FULL) && ((act_state == ACT_EMPTY) || last_use);

    // State registers for both FSMs
    always_ff @(posedge ACLK) begin
        if (!RESET_N) begin
            ld_state  <= LD_FILL;
            act_state <= ACT_EMPTY;
            rdy_en    <= 1'b0;
        end else begin
            ld_state  <= ld_next;
            act_state <= act_next;
            rdy_en    <= 1'b1;
        end
    end

    always_comb begin
        ld_next = ld_state;
        case (ld_state)
            LD_FILL: if (count_beat) ld_next = LD_FULL;
            LD_FULL: if (swap)       ld_next = LD_FILL;
            default:                 ld_next = LD_FILL;
        endcase
    end

    always_comb begin
        act_next = act_state;
        if (swap)          act_next = ACT_RUN;
        else if (last_use) act_next = ACT_EMPTY;
    end

    always_comb begin
        RReady      = rdy_en && (ld_state == LD_FILL);
        FINISH_READ = (ld_state == LD_FULL);
        PARAM_VALID = (act_state == ACT_RUN);
    end

    // Write index and repeat-count capture; a zero count means a single use.
    always_ff @(posedge ACLK) begin
        if (!RESET_N) begin
            wr_idx  <= '0;
            count_q <= '0;
        end else begin
            if (swap)            wr_idx <= '0;
            else if (param_beat) wr_idx <= wr_idx + IDX_W'(1);
            if (count_beat) count_q <= (RByt == '0) ? DATA_W'(1) : RByt;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!RESET_N) begin
            REMAINING <= '0;
            FINISH    <= 1'b0;
            NEXT_ERR  <= 1'b0;
        end else begin
            if (swap)
                REMAINING <= count_q;
            else if ((act_state == ACT_RUN) && NEXT)
                REMAINING <= REMAINING - DATA_W'(1);
            FINISH   <= last_use;
            NEXT_ERR <= (act_state == ACT_EMPTY) && NEXT;
        end
    end

    param_bank #(.DATA_W(DATA_W), .NUM_PARAMS(NUM_PARAMS), .IDX_W(IDX_W)) u_shadow (
        .ACLK      (ACLK),
        .RESET_N   (RESET_N),
        .wr_en     (param_beat),
        .wr_idx    (wr_idx),
        .wr_data   (RByt),
        .load_en   (1'b0),
        .load_data ('0),
        .rd_data   (shadow_data)
    );

    param_bank #(.DATA_W(DATA_W), .NUM_PARAMS(NUM_PARAMS), .IDX_W(IDX_W)) u_active (
        .ACLK      (ACLK),
        .RESET_N   (RESET_N),
        .wr_en     (1'b0),
        .wr_idx    ('0),
        .wr_data   ('0),
        .load_en   (swap),
        .load_data (shadow_data),
        .rd_data   (PARAMS)
    );

endmodule

// File: tb/tb_param_frame_loader.sv
// Scoreboarded bench for param_frame_loader: frames are queued when streamed and
// checked when the bank swap is observed.
module tb_param_frame_loader;

    localparam int DATA_W     = 8;
    localparam int NUM_PARAMS = 4;
    localparam int PW         = NUM_PARAMS * DATA_W;

    typedef struct {
        logic [PW-1:0]     params;
        logic [DATA_W-1:0] count;
    } frame_t;

    logic              ACLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic [DATA_W-1:0] RByt = '0;
    logic              RValid = 1'b0;
    logic              RReady;
    logic              NEXT = 1'b0;
    logic [PW-1:0]     PARAMS;
    logic              PARAM_VALID;
    logic [DATA_W-1:0] REMAINING;
    logic              FINISH, FINISH_READ, NEXT_ERR;

    int     n_tests = 0;
    int     n_fail  = 0;
    frame_t sb_q[$];
    logic   fr_q = 1'b0;

    param_frame_loader #(.DATA_W(DATA_W), .NUM_PARAMS(NUM_PARAMS)) dut (
        .ACLK        (ACLK),
        .RESET_N     (RESET_N),
        .RByt        (RByt),
        .RValid      (RValid),
        .RReady      (RReady),
        .NEXT        (NEXT),
        .PARAMS      (PARAMS),
        .PARAM_VALID (PARAM_VALID),
        .REMAINING   (REMAINING),
        .FINISH      (FINISH),
        .FINISH_READ (FINISH_READ),
        .NEXT_ERR    (NEXT_ERR)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // A falling FINISH_READ marks a swap: the oldest queued frame must now be active.
    always @(negedge ACLK) begin
        frame_t f;
        if (!RESET_N) begin
            fr_q = 1'b0;
        end else begin
            if (fr_q && !FINISH_READ) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    f = sb_q.pop_front();
                    chk("sb_params", 64'(PARAMS), 64'(f.params));
                    chk("sb_remaining", 64'(REMAINING), 64'(f.count == 0 ? 8'd1 : f.count));
                    chk("sb_valid", 64'(PARAM_VALID), 1);
                end
            end
            fr_q = FINISH_READ;
        end
    end

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_beat(input logic [DATA_W-1:0] b);
        int n = 0;
        RValid = 1'b1;
        RByt   = b;
        while (!RReady && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        if (!RReady) chk("beat_timeout", 0, 1);
        @(negedge ACLK);
        RValid = 1'b0;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] p0, p1, p2, p3, cnt);
        frame_t f;
        f.params = {p3, p2, p1, p0};
        f.count  = cnt;
        send_beat(p0);
        send_beat(p1);
        send_beat(p2);
        send_beat(p3);
        sb_q.push_back(f);
        send_beat(cnt);
    endtask

    task automatic pulse_next();
        NEXT = 1'b1;
        @(negedge ACLK);
        NEXT = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_rready"}, 64'(RReady), 0);
        chk({tag, "_params"}, 64'(PARAMS), 0);
        chk({tag, "_pvalid"}, 64'(PARAM_VALID), 0);
        chk({tag, "_remain"}, 64'(REMAINING), 0);
        chk({tag, "_finish"}, 64'(FINISH), 0);
        chk({tag, "_fread"}, 64'(FINISH_READ), 0);
        chk({tag, "_nexterr"}, 64'(NEXT_ERR), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        RESET_N = 1'b0;
        repeat (3) @(negedge ACLK);
        check_idle("rst");
        RESET_N = 1'b1;
        @(negedge ACLK);
        chk("rready_after_rst", 64'(RReady), 1);

        // 1: first frame, FINISH_READ for exactly one cycle
        send_frame(8'd10, 8'd20, 8'd30, 8'd40, 8'd2);
        chk("t1_fread_hi", 64'(FINISH_READ), 1);
        chk("t1_pvalid_lo", 64'(PARAM_VALID), 0);
        @(negedge ACLK);
        chk("t1_fread_lo", 64'(FINISH_READ), 0);
        chk("t1_params", 64'(PARAMS), 64'h281E140A);
        chk("t1_remain", 64'(REMAINING), 2);

        // 2: consume both uses
        pulse_next();
        chk("t2_remain1", 64'(REMAINING), 1);
        chk("t2_finish_lo", 64'(FINISH), 0);
        pulse_next();
        chk("t2_remain0", 64'(REMAINING), 0);
        chk("t2_finish_hi", 64'(FINISH), 1);
        chk("t2_pvalid_lo", 64'(PARAM_VALID), 0);
        chk("t2_params_held", 64'(PARAMS), 64'h281E140A);
        @(negedge ACLK);
        chk("t2_finish_1cyc", 64'(FINISH), 0);

        // 3: preload a frame during a count=3 run
        send_frame(8'd1, 8'd2, 8'd3, 8'd4, 8'd3);
        @(negedge ACLK);
        send_frame(8'd5, 8'd6, 8'd7, 8'd8, 8'd1);
        chk("t3_rready_lo", 64'(RReady), 0);
        chk("t3_fread_hi", 64'(FINISH_READ), 1);
        pulse_next();
        pulse_next();
        chk("t3_remain1", 64'(REMAINING), 1);
        chk("t3_still_full", 64'(FINISH_READ), 1);
        chk("t3_old_params", 64'(PARAMS), 64'h04030201);
        pulse_next();
        chk("t3_new_params", 64'(PARAMS), 64'h08070605);
        chk("t3_remain_new", 64'(REMAINING), 1);
        chk("t3_pvalid_kept", 64'(PARAM_VALID), 1);
        chk("t3_finish", 64'(FINISH), 1);
        chk("t3_fread_lo", 64'(FINISH_READ), 0);
        @(negedge ACLK);
        chk("t3_rready_back", 64'(RReady), 1);
        pulse_next();
        chk("t3_finish2", 64'(FINISH), 1);
        chk("t3_empty", 64'(PARAM_VALID), 0);

        // 4: NEXT while empty, then count 0 treated as one use
        pulse_next();
        chk("t4_nexterr", 64'(NEXT_ERR), 1);
        chk("t4_remain", 64'(REMAINING), 0);
        chk("t4_params_held", 64'(PARAMS), 64'h08070605);
        @(negedge ACLK);
        chk("t4_nexterr_1cyc", 64'(NEXT_ERR), 0);
        send_frame(8'h21, 8'h22, 8'h23, 8'h24, 8'd0);
        @(negedge ACLK);
        chk("t4_cnt0_remain", 64'(REMAINING), 1);
        pulse_next();
        chk("t4_cnt0_finish", 64'(FINISH), 1);
        chk("t4_cnt0_empty", 64'(PARAM_VALID), 0);
        chk("t4_no_err", 64'(NEXT_ERR), 0);

        // 5: beats offered while RReady=0 must be dropped
        send_frame(8'h31, 8'h32, 8'h33, 8'h34, 8'd1);
        @(negedge ACLK);
        send_frame(8'h41, 8'h42, 8'h43, 8'h44, 8'd1);
        RValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            RByt = 8'hE0 + 8'(i);
            chk("t5_rready_lo", 64'(RReady), 0);
            @(negedge ACLK);
        end
        RValid = 1'b0;
        pulse_next();
        chk("t5_swap_params", 64'(PARAMS), 64'h44434241);
        @(negedge ACLK);
        send_frame(8'h51, 8'h52, 8'h53, 8'h54, 8'd1);
        pulse_next();
        chk("t5_next_params", 64'(PARAMS), 64'h54535251);

        // 6: reset mid-frame discards everything
        send_beat(8'h61);
        send_beat(8'h62);
        RESET_N = 1'b0;
        @(negedge ACLK);
        check_idle("t6_rst");
        RESET_N = 1'b1;
        @(negedge ACLK);
        send_frame(8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'd2);
        @(negedge ACLK);
        chk("t6_params", 64'(PARAMS), 64'hA4A3A2A1);
        chk("t6_remain", 64'(REMAINING), 2);
        chk("t6_pvalid", 64'(PARAM_VALID), 1);

        repeat (2) @(negedge ACLK);
        chk("sb_drained", 64'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
